pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - in-order issue controller with register scoreboard, branch hold and halt drain
module pipeline_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_id_valid,
    input  logic [31:0] if_id_instr,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic        br_resolve,
    input  logic        br_taken,
    output logic        stall,
    output logic        id_ex_valid,
    output logic        if_id_flush,
    output logic        halted,
    output logic [31:0] busy,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BRANCH = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    state_t      state_q;
    logic        id_ex_valid_q;
    logic        if_id_flush_q;
    logic        halted_q;
    logic [31:0] busy_q, busy_d;
    logic [15:0] stall_count_q, stall_count_d;

    // instruction fields
    logic [5:0] op;
    logic [4:0] rs, rt, rd;

    // decoded register usage
    logic       reads_rs, reads_rt, writes_reg;
    logic [4:0] wr_reg;
    logic       is_branch, is_halt;

    logic       hazard;
    logic       issue;

    // only the opcode and register fields participate in control decisions
    logic       unused_instr_bits;
    assign unused_instr_bits = ^if_id_instr[10:0];

    assign op = if_id_instr[31:26];
    assign rs = if_id_instr[25:21];
    assign rt = if_id_instr[20:16];
    assign rd = if_id_instr[15:11];

    // decode which registers the instruction in IF/ID reads and writes
    always_comb begin
        reads_rs   = 1'b0;
        reads_rt   = 1'b0;
        writes_reg = 1'b0;
        wr_reg     = 5'd0;
        is_branch  = 1'b0;
        is_halt    = 1'b0;
        case (op)
            6'b000000, 6'b000001, 6'b000011, 6'b000100,
            6'b000101, 6'b000110, 6'b000111, 6'b001100: begin
                reads_rs   = 1'b1;
                reads_rt   = 1'b1;
                writes_reg = 1'b1;
                wr_reg     = rd;
            end
            6'b000010: begin            // LI
                writes_reg = 1'b1;
                wr_reg     = rt;
            end
            6'b001010: begin            // MOV
                reads_rs   = 1'b1;
                writes_reg = 1'b1;
                wr_reg     = rd;
            end
            6'b001011: begin            // ADI
                reads_rs   = 1'b1;
                writes_reg = 1'b1;
                wr_reg     = rt;
            end
            6'b001000: begin            // BR
                is_branch  = 1'b1;
            end
            6'b001001: begin            // BNE
                reads_rs   = 1'b1;
                reads_rt   = 1'b1;
                is_branch  = 1'b1;
            end
            6'b001101: begin            // HLT
                is_halt    = 1'b1;
            end
            default: begin              // NOP and unassigned opcodes
                reads_rs   = 1'b0;
            end
        endcase
    end

    // RAW and WAW hazards against the registered scoreboard; a writeback
    // landing this cycle is deliberately not bypassed
    always_comb begin
        hazard = 1'b0;
        if (reads_rs && busy_q[rs]) begin
            hazard = 1'b1;
        end
        if (reads_rt && busy_q[rt]) begin
            hazard = 1'b1;
        end
        if (writes_reg && busy_q[wr_reg]) begin
            hazard = 1'b1;
        end
    end

    assign issue = if_id_valid && (state_q == ST_RUN) && !hazard;
    assign stall = if_id_valid && !issue;

    // scoreboard next state: clear on writeback first so a same-cycle
    // issue to the same register wins and keeps the bit set
    always_comb begin
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_reg] = 1'b0;
        end
        if (issue && writes_reg) begin
            busy_d[wr_reg] = 1'b1;
        end
    end

    // stall counter sticks at all-ones instead of wrapping
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // control FSM with its registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_RUN;
            id_ex_valid_q <= 1'b0;
            if_id_flush_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            id_ex_valid_q <= issue;
            if_id_flush_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (issue && is_branch) begin
                        state_q <= ST_BRANCH;
                    end else if (issue && is_halt) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_BRANCH: begin
                    if (br_resolve) begin
                        if_id_flush_q <= br_taken;
                        state_q       <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (busy_q == 32'd0) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALT: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // scoreboard register; writebacks keep draining in every state
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // stall cycle counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count_q <= 16'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign id_ex_valid = id_ex_valid_q;
    assign if_id_flush = if_id_flush_q;
    assign halted      = halted_q;
    assign busy        = busy_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed vector bench for pipeline_ctrl
module tb_pipeline_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic        br_resolve;
    logic        br_taken;
    logic        stall;
    logic        id_ex_valid;
    logic        if_id_flush;
    logic        halted;
    logic [31:0] busy;
    logic [15:0] stall_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    pipeline_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .if_id_valid (if_id_valid),
        .if_id_instr (if_id_instr),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .br_resolve  (br_resolve),
        .br_taken    (br_taken),
        .stall       (stall),
        .id_ex_valid (id_ex_valid),
        .if_id_flush (if_id_flush),
        .halted      (halted),
        .busy        (busy),
        .stall_count (stall_count)
    );

    typedef struct {
        bit          rst;
        bit          v;
        logic [31:0] instr;
        bit          wv;
        logic [4:0]  wr;
        bit          brr;
        bit          brt;
        bit          e_stall;
        bit          e_idex;
        bit          e_flush;
        bit          e_halt;
        logic [31:0] e_busy;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    task automatic add(input bit rst, input bit v, input logic [31:0] instr,
                       input bit wv, input logic [4:0] wr, input bit brr, input bit brt,
                       input bit es, input bit ei, input bit ef, input bit eh,
                       input logic [31:0] eb, input logic [15:0] ec);
        vec_t r;
        r.rst = rst; r.v = v; r.instr = instr; r.wv = wv; r.wr = wr;
        r.brr = brr; r.brt = brt; r.e_stall = es; r.e_idex = ei;
        r.e_flush = ef; r.e_halt = eh; r.e_busy = eb; r.e_cnt = ec;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // drive one row, check combinational stall, clock, check registered outputs
    task automatic apply(input int row, input vec_t r);
        reset       = r.rst;
        if_id_valid = r.v;
        if_id_instr = r.instr;
        wb_valid    = r.wv;
        wb_reg      = r.wr;
        br_resolve  = r.brr;
        br_taken    = r.brt;
        #1;
        chk("stall", row, {31'd0, stall}, {31'd0, r.e_stall});
        @(posedge clock);
        #1;
        chk("id_ex_valid", row, {31'd0, id_ex_valid}, {31'd0, r.e_idex});
        chk("if_id_flush", row, {31'd0, if_id_flush}, {31'd0, r.e_flush});
        chk("halted", row, {31'd0, halted}, {31'd0, r.e_halt});
        chk("busy", row, busy, r.e_busy);
        chk("stall_count", row, {16'd0, stall_count}, {16'd0, r.e_cnt});
    endtask

    initial begin
        logic [31:0] nop, a1, a2, hlt;
        vec_t s;
        nop = ins(6'd14, 5'd0, 5'd0, 5'd0);
        a1  = ins(6'd0, 5'd1, 5'd2, 5'd3);
        a2  = ins(6'd0, 5'd3, 5'd4, 5'd7);
        hlt = ins(6'd13, 5'd0, 5'd0, 5'd0);

        reset = 1'b1; if_id_valid = 1'b0; if_id_instr = '0; wb_valid = 1'b0;
        wb_reg = '0; br_resolve = 1'b0; br_taken = 1'b0;

        //  rst v instr                    wv wr brr brt | st ix fl hl busy       cnt
        add(1, 0, nop,                     0, 0, 0, 0,     0, 0, 0, 0, 32'h0,     0);
        add(0, 0, nop,                     0, 0, 0, 0,     0, 0, 0, 0, 32'h0,     0);
        // RAW stall on r3 until its writeback has been registered
        add(0, 1, a1,                      0, 0, 0, 0,     0, 1, 0, 0, 32'h8,     0);
        add(0, 1, a2,                      0, 0, 0, 0,     1, 0, 0, 0, 32'h8,     1);
        add(0, 1, a2,                      0, 0, 0, 0,     1, 0, 0, 0, 32'h8,     2);
        add(0, 1, a2,                      1, 3, 0, 0,     1, 0, 0, 0, 32'h0,     3);
        add(0, 1, a2,                      0, 0, 0, 0,     0, 1, 0, 0, 32'h80,    3);
        add(0, 0, nop,                     1, 7, 0, 0,     0, 0, 0, 0, 32'h0,     3);
        // LI then MOV (rt field of MOV names busy r5 but is not read)
        add(0, 1, ins(6'd2, 0, 5, 0),      0, 0, 0, 0,     0, 1, 0, 0, 32'h20,    3);
        add(0, 1, ins(6'd10, 1, 5, 6),     0, 0, 0, 0,     0, 1, 0, 0, 32'h60,    3);
        add(0, 0, nop,                     1, 5, 0, 0,     0, 0, 0, 0, 32'h40,    3);
        add(0, 0, nop,                     1, 6, 0, 0,     0, 0, 0, 0, 32'h0,     3);
        // same-cycle set and clear of r9 keeps it set; then WAW stall
        add(0, 1, ins(6'd2, 0, 9, 0),      1, 9, 0, 0,     0, 1, 0, 0, 32'h200,   3);
        add(0, 1, ins(6'd2, 0, 9, 0),      0, 0, 0, 0,     1, 0, 0, 0, 32'h200,   4);
        add(0, 0, nop,                     1, 9, 0, 0,     0, 0, 0, 0, 32'h0,     4);
        // BNE, idle, taken resolve with one-cycle flush
        add(0, 1, ins(6'd9, 1, 2, 0),      0, 0, 0, 0,     0, 1, 0, 0, 32'h0,     4);
        add(0, 0, nop,                     0, 0, 0, 0,     0, 0, 0, 0, 32'h0,     4);
        add(0, 0, nop,                     0, 0, 0, 0,     0, 0, 0, 0, 32'h0,     4);
        add(0, 0, nop,                     0, 0, 0, 0,     0, 0, 0, 0, 32'h0,     4);
        add(0, 1, nop,                     0, 0, 0, 0,     1, 0, 0, 0, 32'h0,     5);
        add(0, 1, nop,                     0, 0, 1, 1,     1, 0, 1, 0, 32'h0,     6);
        add(0, 1, nop,                     0, 0, 0, 0,     0, 1, 0, 0, 32'h0,     6);
        // stray resolve in RUN ignored; BR not taken gives no flush
        add(0, 0, nop,                     0, 0, 1, 1,     0, 0, 0, 0, 32'h0,     6);
        add(0, 1, ins(6'd8, 0, 0, 0),      0, 0, 0, 0,     0, 1, 0, 0, 32'h0,     6);
        add(0, 0, nop,                     0, 0, 1, 0,     0, 0, 0, 0, 32'h0,     6);
        add(0, 1, nop,                     0, 0, 0, 0,     0, 1, 0, 0, 32'h0,     6);
        // HLT with r2 pending: drain, then halt one cycle after busy empties
        add(0, 1, ins(6'd2, 0, 2, 0),      0, 0, 0, 0,     0, 1, 0, 0, 32'h4,     6);
        add(0, 1, hlt,                     0, 0, 0, 0,     0, 1, 0, 0, 32'h4,     6);
        add(0, 1, nop,                     0, 0, 0, 0,     1, 0, 0, 0, 32'h4,     7);
        add(0, 0, nop,                     0, 0, 0, 0,     0, 0, 0, 0, 32'h4,     7);
        add(0, 0, nop,                     1, 2, 0, 0,     0, 0, 0, 0, 32'h0,     7);
        add(0, 0, nop,                     0, 0, 0, 0,     0, 0, 0, 1, 32'h0,     7);
        add(0, 1, nop,                     0, 0, 0, 0,     1, 0, 0, 1, 32'h0,     8);
        add(0, 1, ins(6'd2, 0, 1, 0),      0, 0, 0, 0,     1, 0, 0, 1, 32'h0,     9);
        // reset leaves HALT with a writeback present
        add(1, 0, nop,                     1, 0, 0, 0,     0, 0, 0, 0, 32'h0,     0);
        add(0, 1, nop,                     0, 0, 0, 0,     0, 1, 0, 0, 32'h0,     0);
        // fill r0..r7, enter BRANCH, stall, then reset mid-branch
        for (int i = 0; i < 8; i++) begin
            add(0, 1, ins(6'd2, 0, 5'(i), 0), 0, 0, 0, 0,  0, 1, 0, 0, (32'd2 << i) - 32'd1, 0);
        end
        add(0, 1, ins(6'd8, 0, 0, 0),      0, 0, 0, 0,     0, 1, 0, 0, 32'hFF,    0);
        add(0, 1, nop,                     0, 0, 0, 0,     1, 0, 0, 0, 32'hFF,    1);
        add(0, 1, nop,                     0, 0, 0, 0,     1, 0, 0, 0, 32'hFF,    2);
        add(1, 0, nop,                     1, 0, 1, 1,     0, 0, 0, 0, 32'h0,     0);
        add(0, 1, a1,                      0, 0, 0, 0,     0, 1, 0, 0, 32'h8,     0);

        @(posedge clock);
        #1;
        foreach (tbl[i]) begin
            apply(i, tbl[i]);
        end

        // saturation: hold a WAW stall on r3 for 70000 cycles
        s = tbl[0];
        s.v = 1'b1; s.instr = a1; s.rst = 1'b0;
        reset = 1'b0; if_id_valid = 1'b1; if_id_instr = a1;
        wb_valid = 1'b0; br_resolve = 1'b0;
        for (int k = 1; k <= 70000; k++) begin
            @(posedge clock);
            #1;
            if (k == 65534) chk("sat_fffe", k, {16'd0, stall_count}, 32'h0000FFFE);
            if (k == 65535) chk("sat_ffff", k, {16'd0, stall_count}, 32'h0000FFFF);
        end
        chk("sat_nowrap", 70000, {16'd0, stall_count}, 32'h0000FFFF);
        chk("sat_stall", 70000, {31'd0, stall}, 32'd1);
        chk("sat_busy", 70000, busy, 32'h8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
